// File: rtl/spike_event_packetizer_if.sv
// ---------------------------------------------------------------------------
// spike_event_packetizer_if
//
// Purpose: bundles every non-clock/reset signal of spike_event_packetizer.
//   That covers the accelerator result handshake, the timestep close
//   handshake, the potential-memory write port, the NoC packet handshake and
//   the status outputs.
//
// Modports:
//   master : environment side (drives results, step_done, pkt_ready)
//   slave  : packetizer side (drives in_ready, step_ack, mem_*, pkt_*,
//            fifo_count, overflow, spike_count)
// ---------------------------------------------------------------------------
interface spike_event_packetizer_if #(
  parameter int NEURON_ID_W = 8,
  parameter int TS_W        = 8,
  parameter int FIFO_DEPTH  = 8
);
  logic                              in_valid;
  logic                              in_ready;
  logic [NEURON_ID_W-1:0]            in_neuron_id;
  logic                              spiked;
  logic [31:0]                       potential_to_mem;
  logic [TS_W-1:0]                   timestep;
  logic                              step_done;
  logic                              step_ack;
  logic                              mem_we;
  logic [NEURON_ID_W-1:0]            mem_addr;
  logic [31:0]                       mem_wdata;
  logic                              pkt_valid;
  logic                              pkt_ready;
  logic [TS_W+NEURON_ID_W-1:0]       pkt_data;
  logic [$clog2(FIFO_DEPTH):0]       fifo_count;
  logic                              overflow;
  logic [15:0]                       spike_count;

  modport master (
    output in_valid, in_neuron_id, spiked, potential_to_mem, timestep,
           step_done, pkt_ready,
    input  in_ready, step_ack, mem_we, mem_addr, mem_wdata, pkt_valid,
           pkt_data, fifo_count, overflow, spike_count
  );

  modport slave (
    input  in_valid, in_neuron_id, spiked, potential_to_mem, timestep,
           step_done, pkt_ready,
    output in_ready, step_ack, mem_we, mem_addr, mem_wdata, pkt_valid,
           pkt_data, fifo_count, overflow, spike_count
  );
endinterface

// File: rtl/spike_event_packetizer.sv
// ---------------------------------------------------------------------------
// spike_event_packetizer
//
// Purpose: accepts per-neuron results from the accelerator and handles each
//   one in three ways. It writes the potential back to neuron-state memory,
//   buffers spike events {timestep, neuron_id} in a first-word-fall-through
//   FIFO, and streams them to the NoC router. A RUN/DRAIN/ACK state machine
//   closes each timestep: it flushes the FIFO and then pulses step_ack.
//
// Ports:
//   CLK      : clock, rising edge
//   RESET_N  : synchronous active-low reset
//   bus      : spike_event_packetizer_if.slave (result in, memory write,
//              packet out, step handshake, status)
//
// Configuration macro:
//   SPIKE_COUNT_EN : when defined, spike_count counts spikes accepted in the
//                    current timestep (saturating). When undefined, the
//                    counter is absent and spike_count is tied to zero.
// ---------------------------------------------------------------------------
module spike_event_packetizer #(
  parameter int NEURON_ID_W = 8,
  parameter int TS_W        = 8,
  parameter int FIFO_DEPTH  = 8
) (
  input logic                  CLK,
  input logic                  RESET_N,
  spike_event_packetizer_if.slave bus
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = TS_W + NEURON_ID_W;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [ENTRY_W-1:0]     fifo_mem_q [FIFO_DEPTH];
  logic                   in_ready_q, in_ready_d;
  logic                   mem_we_q, mem_we_d;
  logic [NEURON_ID_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]            mem_wdata_q, mem_wdata_d;
  logic                   overflow_q, overflow_d;

  logic accept_s;
  logic push_s;
  logic pop_s;
  logic pkt_valid_s;

  assign accept_s    = bus.in_valid & in_ready_q;
  assign push_s      = accept_s & bus.spiked;
  assign pkt_valid_s = (count_q != {CNT_W{1'b0}});
  assign pop_s       = pkt_valid_s & bus.pkt_ready;

  // Next-state logic for the FSM, FIFO pointers and write-port registers
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    // Pointers wrap for free because FIFO_DEPTH is a power of two
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A result accepted in the step_done cycle is already in the FIFO when
    // DRAIN begins, so an empty FIFO in DRAIN means nothing is in flight.
    case (state_q)
      ST_RUN: begin
        if (bus.step_done) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (count_q == {CNT_W{1'b0}}) begin
          state_d = ST_ACK;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_ACK:  state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase

    // in_ready is registered from next state so it is low throughout reset
    in_ready_d = (state_d == ST_RUN) && (count_d < DEPTH_C);

    mem_we_d = accept_s;
    if (accept_s) begin
      mem_addr_d  = bus.in_neuron_id;
      mem_wdata_d = bus.potential_to_mem;
    end else begin
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
    end

    overflow_d = overflow_q | (bus.in_valid & ~in_ready_q);
  end

  // Control and status registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q     <= ST_RUN;
      rd_ptr_q    <= {PTR_W{1'b0}};
      wr_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {NEURON_ID_W{1'b0}};
      mem_wdata_q <= 32'h0000_0000;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      overflow_q  <= overflow_d;
    end
  end

  // FIFO storage; contents are don't-care once the pointers are reset
  always_ff @(posedge CLK) begin
    if (RESET_N && push_s) begin
      fifo_mem_q[wr_ptr_q] <= {bus.timestep, bus.in_neuron_id};
    end
  end

`ifdef SPIKE_COUNT_EN
  logic [15:0] spike_count_q, spike_count_d;

  // Per-timestep spike counter, saturating, cleared while acknowledging
  always_comb begin
    if (state_q == ST_ACK) begin
      spike_count_d = 16'h0000;
    end else if (push_s && (spike_count_q != 16'hFFFF)) begin
      spike_count_d = spike_count_q + 16'h0001;
    end else begin
      spike_count_d = spike_count_q;
    end
  end

  // Spike counter register
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      spike_count_q <= 16'h0000;
    end else begin
      spike_count_q <= spike_count_d;
    end
  end

  assign bus.spike_count = spike_count_q;
`else
  assign bus.spike_count = 16'h0000;
`endif

  assign bus.in_ready   = in_ready_q;
  assign bus.step_ack   = (state_q == ST_ACK);
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.pkt_valid  = pkt_valid_s;
  // Masked so an empty FIFO presents zero rather than stale storage
  assign bus.pkt_data   = pkt_valid_s ? fifo_mem_q[rd_ptr_q] : {ENTRY_W{1'b0}};
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: doc/spike_event_packetizer.md
# spike_event_packetizer

Downstream stage of the neuron accelerator datapath. It accepts each per-neuron result (updated potential and spike flag) and performs three tasks: it writes the potential back to neuron-state memory, buffers spike events in a FIFO, and emits them as packets to the NoC router interface over a valid/ready handshake. A drain state machine closes each timestep by flushing every buffered spike before acknowledging.

## Interface
Parameters:
- NEURON_ID_W, 8, width of neuron index and memory address
- TS_W, 8, width of timestep tag
- FIFO_DEPTH, 8, spike FIFO entries; power of two, ≥2

Ports:
- CLK  in  1  clock, rising edge
- RESET_N  in  1  reset, synchronous, active-low
- in_valid  in  1  accelerator result valid
- in_ready  out  1  block can accept a result
- in_neuron_id  in  NEURON_ID_W  neuron that produced the result
- spiked  in  1  neuron fired this update
- potential_to_mem  in  32  post-reset potential to store
- timestep  in  TS_W  current timestep tag
- step_done  in  1  one-cycle pulse: all neurons of this timestep issued
- step_ack  out  1  one-cycle pulse: timestep fully flushed
- mem_we  out  1  potential memory write strobe
- mem_addr  out  NEURON_ID_W  write address
- mem_wdata  out  32  write data
- pkt_valid  out  1  spike packet available
- pkt_ready  in  1  router accepts packet
- pkt_data  out  TS_W+NEURON_ID_W  {timestep, neuron_id}
- fifo_count  out  log2(FIFO_DEPTH)+1  occupied entries
- overflow  out  1  sticky: in_valid seen while in_ready low
- spike_count  out  16  spikes accepted in current timestep

## Operation
- FSM states: RUN, DRAIN, ACK. Reset → RUN.
- RUN: in_ready = (fifo_count < FIFO_DEPTH). Accept = in_valid & in_ready.
- On accept, register mem_we=1, mem_addr=in_neuron_id, mem_wdata=potential_to_mem for exactly one cycle. The write happens whether or not the neuron spiked.
- On accept with spiked=1, push {timestep, in_neuron_id} into the FIFO and increment spike_count (saturating at 0xFFFF).
- FIFO is first-word-fall-through. pkt_valid = (fifo_count != 0). pkt_data = head entry. Pop on pkt_valid & pkt_ready.
- Push and pop in the same cycle: fifo_count unchanged and both take effect. Pointers wrap modulo FIFO_DEPTH.
- in_valid & ~in_ready sets overflow. The result is discarded: no memory write and no push. overflow clears only on reset.
- step_done in RUN → DRAIN. step_done in any other state is ignored.
- DRAIN: in_ready=0; the FIFO continues to pop. When fifo_count==0 and no push is in flight → ACK.
- ACK: step_ack=1 for one cycle; spike_count clears to 0; → RUN.
- If in_valid & in_ready coincides with step_done, the result is accepted first and then the FSM enters DRAIN.
- The block never modifies packet contents. The timestep tag is sampled at accept time.

## Timing
- Reset values: in_ready=0 during reset and 1 on the first cycle after release. mem_we=0, mem_addr=0, mem_wdata=0, pkt_valid=0, pkt_data=0, fifo_count=0, overflow=0, spike_count=0, step_ack=0. The FIFO is emptied.
- Memory write latency: mem_we asserts the cycle after accept.
- Spike latency: pkt_valid asserts the cycle after an accept into an empty FIFO.
- in_ready falls in the cycle after the push that fills the FIFO, and rises in the cycle after a pop from a full FIFO.
- pkt_data is stable while pkt_valid=1 and pkt_ready=0.
- step_ack asserts one cycle after the FIFO becomes empty in DRAIN. Minimum step_done→step_ack is 2 cycles, with an empty FIFO.
- RESET_N low mid-DRAIN or mid-transfer: the next edge returns the block to reset values. Buffered spikes are lost and no step_ack is produced.

## Configuration
- SPIKE_COUNT_EN defined: spike_count is implemented as specified.
- SPIKE_COUNT_EN undefined: the counter logic is omitted and spike_count is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then 4 accepts (ids 1–4, spiked=0, potentials 10–40) → 4 mem writes, each one cycle after its accept; pkt_valid stays 0.
- Accept id 5 (spiked=1, timestep 3) with pkt_ready=1 → pkt_data={3,5}, pkt_valid one cycle later for one cycle; spike_count=1.
- pkt_ready=0; accept 8 spiking ids → after the 8th push in_ready=0 and fifo_count=8. Drive in_valid again → overflow=1, with no write and no push.
- With the FIFO full, pop one packet while a new accept arrives after in_ready rises → packet order is preserved; read pointer wraps correctly past entry 7.
- 3 spikes buffered, pkt_ready=0, pulse step_done → in_ready=0 and no step_ack. Raise pkt_ready → 3 packets drain, then step_ack pulses, spike_count clears, and in_ready returns to 1.
- Assert RESET_N low during DRAIN with 2 buffered spikes → all outputs take reset values on the next edge and no step_ack is produced. Build without SPIKE_COUNT_EN → spike_count stays 0 throughout.
